// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 6-digit multiplexed
// 7-segment display driver.
//   NUM_DIGITS - digits scanned per frame
//   SEG_*      - active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   dig_idx_t  - digit slot index (0 = leftmost)
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [2:0] dig_idx_t;

  localparam dig_idx_t IDX_LAST = 3'(NUM_DIGITS - 1);

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to 7-segment decoder.
//   val_i [3:0] - digit value; 10..15 are not BCD and show a dash
//   seg_o [6:0] - active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (val_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 6-digit common-anode 7-segment
// display, fed directly by the six BCD digit outputs of the stopwatch timer.
// Each digit owns a slot of SCAN_DIV cycles; the first DEAD_CYC cycles of a
// slot keep every anode off so the previous digit's segments cannot ghost.
// Digits are sampled into a shadow register once per frame (end of slot 5),
// so a frame never mixes old and new timer values.
//
// Parameters: SCAN_DIV (cycles per slot), DEAD_CYC (anode-off cycles per
//             slot), DP_MASK (bit k lights the decimal point of digit k).
// Ports:
//   clk            - system clock, rising edge
//   reset_n        - asynchronous active-low reset
//   d,e,f,g,h,i    - BCD digits, d leftmost (index 0), i rightmost (index 5)
//   blank          - force all anodes off (scan keeps running)
//   an[5:0]        - anodes, active-low, bit k = digit k
//   seg[6:0]       - segments {g,f,e,d,c,b,a}, active-low
//   dp             - decimal point, active-low
//   frame_done     - one-cycle pulse after each shadow capture
// Build option: SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros on
// digits 0..4 (digit 5 always displays).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int         SCAN_DIV = 50000,
  parameter int         DEAD_CYC = 16,
  parameter logic [5:0] DP_MASK  = 6'b001010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d,
  input  logic [3:0] e,
  input  logic [3:0] f,
  input  logic [3:0] g,
  input  logic [3:0] h,
  input  logic [3:0] i,
  input  logic       blank,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  generate
    if (SCAN_DIV < DEAD_CYC + 2) begin : g_bad_cfg
      $error("seg7_scan: SCAN_DIV must be at least DEAD_CYC+2");
    end
  endgenerate

  logic [DIV_W-1:0]                 div_q, div_d;
  dig_idx_t                         idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]       shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]       digits;
  logic [NUM_DIGITS-1:0][6:0]       dec_seg;
  logic [NUM_DIGITS-1:0]            lz_blank;
  logic                             frame_done_q;
  logic [5:0]                       an_q, an_d;
  logic [6:0]                       seg_q, seg_d;
  logic                             dp_q, dp_d;
  logic                             slot_end, capture, dig_on;

  // index 0 = d (leftmost) ... index 5 = i (rightmost)
  assign digits = {i, h, g, f, e, d};

  // ---------------- scan counters and shadow capture ----------------
  assign slot_end = (div_q == DIV_W'(SCAN_DIV - 1));
  assign capture  = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    div_d    = slot_end ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    shadow_d = capture ? digits : shadow_q;
  end

  // ---------------- per-digit decoders ----------------
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      seg7_decode u_dec (
        .val_i (shadow_q[gi]),
        .seg_o (dec_seg[gi])
      );
    end
  endgenerate

  // ---------------- leading-zero suppression ----------------
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is suppressed while it and every digit to its left is zero;
  // the rightmost digit is excluded so "0" still shows for an all-zero value.
  always_comb begin
    logic run;
    lz_blank = '0;
    run      = 1'b1;
    for (int k = 0; k < NUM_DIGITS - 1; k++) begin
      run         = run && (shadow_q[k] == 4'd0);
      lz_blank[k] = run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // ---------------- registered display outputs ----------------
  assign dig_on = (div_q >= DIV_W'(DEAD_CYC)) && !blank && !lz_blank[idx_q];

  always_comb begin
    an_d = '1;
    if (dig_on) an_d[idx_q] = 1'b0;
    // segments are held dark whenever no anode is lit
    seg_d = dig_on ? dec_seg[idx_q] : SEG_BLANK;
    dp_d  = !(dig_on && DP_MASK[idx_q]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      frame_done_q <= capture;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed self-checking bench for seg7_scan with
// SCAN_DIV=8, DEAD_CYC=2 (48-cycle frames). Outputs are sampled on the
// falling clock edge. After the negedge on which frame_done is seen, the
// j-th following negedge shows outputs derived from scan step s=j-1:
// slot position s%8, digit index s/8.
module tb_seg7_scan;

  localparam int SD = 8;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] d, e, f, g, h, i;
  logic       blank;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_DIV(SD), .DEAD_CYC(DC), .DP_MASK(6'b001010)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .i          (i),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // hand-written reference patterns, {g,f,e,d,c,b,a} active-low
  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // advances to the next negedge carrying frame_done, bounded
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_digits(input logic [3:0] a0, a1, a2, a3, a4, a5);
    d = a0; e = a1; f = a2; g = a3; h = a4; i = a5;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    blank   = 1'b0;
    set_digits(1, 2, 3, 4, 5, 6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: an=%b seg=%b dp=%b fd=%b, want 111111 1111111 1 0",
                 c, an, seg, dp, frame_done);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_scan;
    bit ok;
    int cnt [6];
    foreach (cnt[k]) cnt[k] = 0;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL scan_sync: no frame_done within 200 cycles"); end
    for (int j = 1; j <= 48; j++) begin
      int s, di, ix;
      bit on;
      logic [5:0] ea;
      logic       ed;
      @(negedge clk);
      s = j - 1; di = s % SD; ix = s / SD;
      on = (di >= DC);
      ea = on ? ~(6'b000001 << ix) : 6'b111111;
      ed = !(on && (ix == 1 || ix == 3));
      if (an[ix] === 1'b0) cnt[ix]++;
      n_chk++;
      if (an !== ea || dp !== ed || frame_done !== (j == 48)) begin
        n_fail++;
        $display("FAIL scan_an_dp j=%0d: an=%b dp=%b fd=%b, want %b %b %b",
                 j, an, dp, frame_done, ea, ed, (j == 48));
      end
      if (on) begin
        n_chk++;
        if (seg !== exp_seg(4'(ix + 1))) begin
          n_fail++;
          $display("FAIL scan_seg j=%0d idx=%0d: seg=%b, want %b", j, ix, seg, exp_seg(4'(ix + 1)));
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      n_chk++;
      if (cnt[k] != 6) begin
        n_fail++;
        $display("FAIL scan_duty idx=%0d: active %0d cycles, want 6", k, cnt[k]);
      end
    end
  endtask

  task automatic test_no_tear;
    bit ok;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL tear_sync: no frame_done within 200 cycles"); end
    for (int j = 1; j <= 48; j++) begin
      @(negedge clk);
      if (j == 2) d = 4'd7;
      if (j >= 3 && j <= 8) begin
        n_chk++;
        if (an !== 6'b111110 || seg !== 7'b1111001) begin
          n_fail++;
          $display("FAIL tear_old j=%0d: an=%b seg=%b, want 111110 1111001", j, an, seg);
        end
      end
    end
    n_chk++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL tear_fd: frame_done=%b at cycle 48, want 1", frame_done);
    end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        n_chk++;
        if (an !== 6'b111110 || seg !== 7'b1111000) begin
          n_fail++;
          $display("FAIL tear_new j=%0d: an=%b seg=%b, want 111110 1111000", j, an, seg);
        end
      end
    end
  endtask

  task automatic test_dash;
    bit ok;
    d = 4'hC;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL dash_sync: no frame_done within 200 cycles"); end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        n_chk++;
        if (an !== 6'b111110 || seg !== 7'b0111111) begin
          n_fail++;
          $display("FAIL dash j=%0d: an=%b seg=%b, want 111110 0111111", j, an, seg);
        end
      end
    end
  endtask

  task automatic test_lead_zero;
    bit ok;
    int cnt [6];
    int ecnt;
    foreach (cnt[k]) cnt[k] = 0;
    set_digits(0, 0, 0, 1, 0, 5);
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL lz_sync: no frame_done within 200 cycles"); end
    for (int j = 1; j <= 48; j++) begin
      int ix;
      @(negedge clk);
      ix = (j - 1) / SD;
      for (int k = 0; k < 6; k++) if (an[k] === 1'b0) cnt[k]++;
      if (ix == 4 && an[4] === 1'b0) begin
        n_chk++;
        if (seg !== 7'b1000000) begin
          n_fail++;
          $display("FAIL lz_h_zero j=%0d: seg=%b, want 1000000", j, seg);
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      ecnt = (k < 3) ? 0 : 6;
`else
      ecnt = 6;
`endif
      n_chk++;
      if (cnt[k] != ecnt) begin
        n_fail++;
        $display("FAIL lz_anode idx=%0d: active %0d cycles, want %0d", k, cnt[k], ecnt);
      end
    end
  endtask

  task automatic test_blank;
    bit ok;
    set_digits(1, 2, 3, 4, 5, 6);
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL blank_sync: no frame_done within 200 cycles"); end
    repeat (4) @(negedge clk);
    n_chk++;
    if (an !== 6'b111110) begin
      n_fail++;
      $display("FAIL blank_pre: an=%b, want 111110", an);
    end
    blank = 1'b1;
    // two full frames under blank: anodes dark, frame_done still every 48
    for (int j = 5; j <= 96; j++) begin
      @(negedge clk);
      if (j == 50) d = 4'd9;
      n_chk++;
      if (an !== 6'b111111 || dp !== 1'b1 || frame_done !== (j == 48 || j == 96)) begin
        n_fail++;
        $display("FAIL blank_hold j=%0d: an=%b dp=%b fd=%b, want 111111 1 %b",
                 j, an, dp, frame_done, (j == 48 || j == 96));
      end
    end
    blank = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        n_chk++;
        if (an !== 6'b111110 || seg !== 7'b0010000) begin
          n_fail++;
          $display("FAIL blank_capture j=%0d: an=%b seg=%b, want 111110 0010000", j, an, seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    set_digits(1, 2, 3, 4, 5, 6);
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rst_sync: no frame_done within 200 cycles"); end
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: an=%b seg=%b dp=%b fd=%b, want 111111 1111111 1 0",
               an, seg, dp, frame_done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // shadow is zero until the first capture at step 48
    for (int r = 1; r <= 48; r++) begin
      int s, di, ix;
      bit on;
      logic [5:0] ea;
      @(negedge clk);
      s = r - 1; di = s % SD; ix = s / SD;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      on = (di >= DC) && (ix == 5);
`else
      on = (di >= DC);
`endif
      ea = on ? ~(6'b000001 << ix) : 6'b111111;
      n_chk++;
      if (an !== ea || frame_done !== (r == 48) || (on && seg !== 7'b1000000)) begin
        n_fail++;
        $display("FAIL rst_restart r=%0d: an=%b seg=%b fd=%b, want an=%b fd=%b seg(if lit)=1000000",
                 r, an, seg, frame_done, ea, (r == 48));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_no_tear();
    test_dash();
    test_lead_zero();
    test_blank();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
